// File: rtl/video_dnn_argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_dnn_argmax_pkg
// Purpose  : Shared constants and elaboration helpers for the argmax stage.
// Revision : 1.0 - initial release
// ============================================================================
package video_dnn_argmax_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Number of surviving candidates entering tree stage s (odd leftovers carried).
    function automatic int lanes_at(input int n, input int s);
        int r;
        r = n;
        for (int i = 0; i < s; i++) r = (r + 1) / 2;
        return r;
    endfunction

    localparam int NUM_CLASS_DEFAULT   = 10;
    localparam int COUNT_WIDTH_DEFAULT = 3;
    localparam int STAGES              = clog2(NUM_CLASS_DEFAULT);
    localparam int TCOUNT_WIDTH        = NUM_CLASS_DEFAULT * COUNT_WIDTH_DEFAULT;
    localparam int BG_CLASS            = NUM_CLASS_DEFAULT;

endpackage
`default_nettype wire

// File: rtl/video_dnn_argmax_node.sv
`default_nettype none
// ============================================================================
// Module   : video_dnn_argmax_node
// Purpose  : Registered two-input compare node; 'a' must be the lower index.
// Revision : 1.0 - initial release
// ============================================================================
module video_dnn_argmax_node #(
    parameter int CLASS_WIDTH = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   aclk,
    input  logic                   cke,
    input  logic [CLASS_WIDTH-1:0] a_idx,
    input  logic [COUNT_WIDTH-1:0] a_cnt,
    input  logic [CLASS_WIDTH-1:0] b_idx,
    input  logic [COUNT_WIDTH-1:0] b_cnt,
    output logic [CLASS_WIDTH-1:0] win_idx,
    output logic [COUNT_WIDTH-1:0] win_cnt
);

    // Only a strictly larger count lets the higher index win, so ties keep 'a'.
    always_ff @(posedge aclk) begin
        if (cke) begin
            if (b_cnt > a_cnt) begin
                win_idx <= b_idx;
                win_cnt <= b_cnt;
            end else begin
                win_idx <= a_idx;
                win_cnt <= a_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_dnn_argmax.sv
`default_nettype none
// ============================================================================
// Module   : video_dnn_argmax
// Purpose  : Per-pixel winning-class selection with threshold and per-frame
//            winning-class histogram.
// Revision : 1.0 - initial release
// ============================================================================
module video_dnn_argmax #(
    parameter int NUM_CLASS   = 10,
    parameter int COUNT_WIDTH = 3,
    parameter int CLASS_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int HIST_WIDTH  = 20
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  aclken,
    input  logic [COUNT_WIDTH-1:0]                threshold,
    input  logic [TUSER_WIDTH-1:0]                s_axi4s_tuser,
    input  logic                                  s_axi4s_tlast,
    input  logic [NUM_CLASS*COUNT_WIDTH-1:0]      s_axi4s_tcount,
    input  logic                                  s_axi4s_tvalid,
    output logic                                  s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]                m_axi4s_tuser,
    output logic                                  m_axi4s_tlast,
    output logic [CLASS_WIDTH-1:0]                m_axi4s_tclass,
    output logic [COUNT_WIDTH-1:0]                m_axi4s_tmax,
    output logic                                  m_axi4s_tvalid,
    input  logic                                  m_axi4s_tready,
    output logic [(NUM_CLASS+1)*HIST_WIDTH-1:0]   hist_counts,
    output logic                                  hist_valid
);
    import video_dnn_argmax_pkg::*;

    localparam int TREE_STAGES = clog2(NUM_CLASS);
    localparam logic [CLASS_WIDTH-1:0] c_bg_class = CLASS_WIDTH'(NUM_CLASS);
    localparam logic [HIST_WIDTH-1:0]  c_bin_max  = {HIST_WIDTH{1'b1}};

    logic w_cke;
    logic w_out_hs;

    assign w_cke          = aclken & (~m_axi4s_tvalid | m_axi4s_tready);
    assign s_axi4s_tready = w_cke;
    assign w_out_hs       = aclken & m_axi4s_tvalid & m_axi4s_tready;

    // Level 0 is the raw input; level s+1 is the registered output of stage s.
    logic [CLASS_WIDTH-1:0] w_idx [0:TREE_STAGES][0:NUM_CLASS-1];
    logic [COUNT_WIDTH-1:0] w_cnt [0:TREE_STAGES][0:NUM_CLASS-1];

    for (genvar l = 0; l < NUM_CLASS; l++) begin : g_lane
        assign w_idx[0][l] = CLASS_WIDTH'(l);
        assign w_cnt[0][l] = s_axi4s_tcount[l*COUNT_WIDTH +: COUNT_WIDTH];
    end

    for (genvar s = 0; s < TREE_STAGES; s++) begin : g_stage
        localparam int N_IN = lanes_at(NUM_CLASS, s);
        for (genvar k = 0; k < NUM_CLASS; k++) begin : g_node
            if (2*k + 1 < N_IN) begin : g_pair
                video_dnn_argmax_node #(
                    .CLASS_WIDTH (CLASS_WIDTH),
                    .COUNT_WIDTH (COUNT_WIDTH)
                ) u_node (
                    .aclk    (aclk),
                    .cke     (w_cke),
                    .a_idx   (w_idx[s][2*k]),
                    .a_cnt   (w_cnt[s][2*k]),
                    .b_idx   (w_idx[s][2*k+1]),
                    .b_cnt   (w_cnt[s][2*k+1]),
                    .win_idx (w_idx[s+1][k]),
                    .win_cnt (w_cnt[s+1][k])
                );
            end else if (2*k < N_IN) begin : g_pass
                // Odd leftover: a zero-count rival can never strictly beat it.
                video_dnn_argmax_node #(
                    .CLASS_WIDTH (CLASS_WIDTH),
                    .COUNT_WIDTH (COUNT_WIDTH)
                ) u_node (
                    .aclk    (aclk),
                    .cke     (w_cke),
                    .a_idx   (w_idx[s][2*k]),
                    .a_cnt   (w_cnt[s][2*k]),
                    .b_idx   (w_idx[s][2*k]),
                    .b_cnt   ({COUNT_WIDTH{1'b0}}),
                    .win_idx (w_idx[s+1][k]),
                    .win_cnt (w_cnt[s+1][k])
                );
            end else begin : g_unused
                assign w_idx[s+1][k] = '0;
                assign w_cnt[s+1][k] = '0;
            end
        end
    end

    logic [TREE_STAGES-1:0] r_vld;
    logic [TREE_STAGES-1:0] r_last;
    logic [TUSER_WIDTH-1:0] r_user [0:TREE_STAGES-1];
    logic [COUNT_WIDTH-1:0] r_thr  [0:TREE_STAGES-1];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_vld <= '0;
        end else if (w_cke) begin
            r_vld[0] <= s_axi4s_tvalid;
            for (int i = 1; i < TREE_STAGES; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge aclk) begin
        if (w_cke) begin
            r_user[0] <= s_axi4s_tuser;
            r_last[0] <= s_axi4s_tlast;
            r_thr[0]  <= threshold;
            for (int i = 1; i < TREE_STAGES; i++) begin
                r_user[i] <= r_user[i-1];
                r_last[i] <= r_last[i-1];
                r_thr[i]  <= r_thr[i-1];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axi4s_tvalid <= 1'b0;
        end else if (w_cke) begin
            m_axi4s_tvalid <= r_vld[TREE_STAGES-1];
        end
    end

    always_ff @(posedge aclk) begin
        if (w_cke) begin
            m_axi4s_tuser  <= r_user[TREE_STAGES-1];
            m_axi4s_tlast  <= r_last[TREE_STAGES-1];
            m_axi4s_tmax   <= w_cnt[TREE_STAGES][0];
            m_axi4s_tclass <= (w_cnt[TREE_STAGES][0] < r_thr[TREE_STAGES-1])
                              ? c_bg_class : w_idx[TREE_STAGES][0];
        end
    end

    // Live bins count the current frame; the frame-start pixel publishes them.
    logic [HIST_WIDTH-1:0] r_live [0:NUM_CLASS];
    logic [HIST_WIDTH-1:0] r_hist [0:NUM_CLASS];
    logic                  r_hist_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int b = 0; b <= NUM_CLASS; b++) begin
                r_live[b] <= '0;
                r_hist[b] <= '0;
            end
            r_hist_valid <= 1'b0;
        end else if (aclken) begin
            r_hist_valid <= w_out_hs & m_axi4s_tuser[0];
            if (w_out_hs) begin
                for (int b = 0; b <= NUM_CLASS; b++) begin
                    if (m_axi4s_tuser[0]) begin
                        r_hist[b] <= r_live[b];
                        r_live[b] <= (int'(m_axi4s_tclass) == b) ? HIST_WIDTH'(1) : '0;
                    end else if ((int'(m_axi4s_tclass) == b) && (r_live[b] != c_bin_max)) begin
                        r_live[b] <= r_live[b] + HIST_WIDTH'(1);
                    end
                end
            end
        end
    end

    for (genvar b = 0; b <= NUM_CLASS; b++) begin : g_hist
        assign hist_counts[b*HIST_WIDTH +: HIST_WIDTH] = r_hist[b];
    end

    assign hist_valid = r_hist_valid;

endmodule
`default_nettype wire

// File: tb/tb_video_dnn_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_dnn_argmax
// Purpose  : Self-checking bench: vector table, scoreboard against a
//            behavioural argmax model, histogram and reset/enable sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_dnn_argmax;

    localparam int NC  = 10;
    localparam int CW  = 3;
    localparam int KW  = 4;
    localparam int UW  = 1;
    localparam int HW  = 20;
    localparam int HW2 = 3;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic                  aclken;
    logic [CW-1:0]         threshold;
    logic [UW-1:0]         s_tuser;
    logic                  s_tlast;
    logic [NC*CW-1:0]      s_tcount;
    logic                  s_tvalid;
    logic                  s_tready, s_tready2;
    logic [UW-1:0]         m_tuser, m_tuser2;
    logic                  m_tlast, m_tlast2;
    logic [KW-1:0]         m_tclass, m_tclass2;
    logic [CW-1:0]         m_tmax, m_tmax2;
    logic                  m_tvalid, m_tvalid2;
    logic                  m_tready;
    logic [(NC+1)*HW-1:0]  hist_counts;
    logic [(NC+1)*HW2-1:0] hist_counts2;
    logic                  hist_valid, hist_valid2;

    always #5 aclk = ~aclk;

    video_dnn_argmax #(.NUM_CLASS(NC), .COUNT_WIDTH(CW), .CLASS_WIDTH(KW),
                       .TUSER_WIDTH(UW), .HIST_WIDTH(HW)) dut (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .threshold(threshold),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tcount(s_tcount),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tclass(m_tclass),
        .m_axi4s_tmax(m_tmax), .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
        .hist_counts(hist_counts), .hist_valid(hist_valid)
    );

    video_dnn_argmax #(.NUM_CLASS(NC), .COUNT_WIDTH(CW), .CLASS_WIDTH(KW),
                       .TUSER_WIDTH(UW), .HIST_WIDTH(HW2)) dut_sat (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .threshold(threshold),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tcount(s_tcount),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready2),
        .m_axi4s_tuser(m_tuser2), .m_axi4s_tlast(m_tlast2), .m_axi4s_tclass(m_tclass2),
        .m_axi4s_tmax(m_tmax2), .m_axi4s_tvalid(m_tvalid2), .m_axi4s_tready(m_tready),
        .hist_counts(hist_counts2), .hist_valid(hist_valid2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_hist(input string name, input logic [(NC+1)*HW-1:0] act,
                            input logic [(NC+1)*HW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first lane holding the largest count; below threshold -> NC.
    function automatic void ref_argmax(input logic [NC*CW-1:0] c, input logic [CW-1:0] thr,
                                       output int cls, output int mx);
        mx  = -1;
        cls = 0;
        for (int i = 0; i < NC; i++) begin
            int v;
            v = int'(c[i*CW +: CW]);
            if (v > mx) begin
                mx  = v;
                cls = i;
            end
        end
        if (mx < int'(thr)) cls = NC;
    endfunction

    function automatic logic [NC*CW-1:0] mk(input int fill, input int la, input int va,
                                            input int lb, input int vb);
        logic [NC*CW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(fill);
        if (la >= 0) r[la*CW +: CW] = CW'(va);
        if (lb >= 0) r[lb*CW +: CW] = CW'(vb);
        return r;
    endfunction

    typedef struct packed {
        logic [KW-1:0] cls;
        logic [CW-1:0] mx;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    logic stalled = 1'b0;
    logic [KW+CW+UW+1:0] held;

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", 64'({m_tvalid, m_tclass, m_tmax, m_tuser, m_tlast}), 64'(held));
            if (aclken && m_tvalid && m_tready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_out", 64'({m_tclass, m_tmax, m_tuser, m_tlast}), 64'(e));
                end
            end
            if (s_tvalid && s_tready) begin
                int c, m;
                exp_t e;
                ref_argmax(s_tcount, threshold, c, m);
                e.cls  = KW'(c);
                e.mx   = CW'(m);
                e.user = s_tuser;
                e.last = s_tlast;
                exp_q.push_back(e);
            end
            stalled = m_tvalid && !m_tready;
            held    = {m_tvalid, m_tclass, m_tmax, m_tuser, m_tlast};
        end
    end

    int hv_cnt = 0, hv2_cnt = 0;
    logic [(NC+1)*HW-1:0]  hv_snap;
    logic [(NC+1)*HW2-1:0] hv2_snap;

    always @(negedge aclk) begin
        if (!aresetn) begin
            hv_cnt  = 0;
            hv2_cnt = 0;
        end else if (aclken) begin
            if (hist_valid) begin
                hv_cnt++;
                hv_snap = hist_counts;
            end
            if (hist_valid2) begin
                hv2_cnt++;
                hv2_snap = hist_counts2;
            end
        end
    end

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send(input logic [NC*CW-1:0] c, input logic [CW-1:0] thr,
                        input logic u, input logic l);
        logic ok;
        int   guard;
        guard    = 0;
        ok       = 1'b0;
        s_tcount = c;
        threshold = thr;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!ok && guard < 200) begin
            @(negedge aclk);
            ok = s_tready;
            cycle();
            guard++;
        end
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        repeat (2) cycle();
        aresetn = 1'b1;
    endtask

    typedef struct {
        logic [NC*CW-1:0] cnt;
        logic [CW-1:0]    thr;
        int               ecls;
        int               emax;
    } vec_t;

    vec_t vecs[12];
    logic [(NC+1)*HW-1:0] hexp;
    bit rnd_done;

    initial begin
        aresetn   = 1'b0;
        aclken    = 1'b1;
        m_tready  = 1'b1;
        s_tvalid  = 1'b0;
        s_tuser   = '0;
        s_tlast   = 1'b0;
        s_tcount  = '0;
        threshold = '0;

        vecs[0]  = '{mk(2, 3, 7, -1, 0), 3'd0, 3, 7};
        vecs[1]  = '{mk(0, 1, 5, 6, 5),  3'd0, 1, 5};
        vecs[2]  = '{mk(4, -1, 0, -1, 0), 3'd0, 0, 4};
        vecs[3]  = '{mk(0, 8, 3, -1, 0), 3'd4, 10, 3};
        vecs[4]  = '{mk(0, 8, 3, -1, 0), 3'd3, 8, 3};
        vecs[5]  = '{mk(0, -1, 0, -1, 0), 3'd0, 0, 0};
        vecs[6]  = '{mk(0, -1, 0, -1, 0), 3'd1, 10, 0};
        vecs[7]  = '{mk(7, -1, 0, -1, 0), 3'd7, 0, 7};
        vecs[8]  = '{mk(5, 9, 6, -1, 0), 3'd6, 9, 6};
        vecs[9]  = '{mk(1, 3, 7, 4, 7),  3'd0, 3, 7};
        vecs[10] = '{mk(3, 0, 5, 9, 5),  3'd5, 0, 5};
        vecs[11] = '{mk(3, 9, 4, -1, 0), 3'd0, 9, 4};

        do_reset();
        chk("reset_tvalid", 64'(m_tvalid), 64'(0));
        chk("reset_hist_valid", 64'(hist_valid), 64'(0));
        chk_hist("reset_hist", hist_counts, '0);
        chk("reset_hist_sat", 64'(hist_counts2), 64'(0));

        // Vector table: one pixel at a time, latency and values against constants.
        for (int v = 0; v < 12; v++) begin
            int lat;
            logic u, l;
            u = (v % 3 == 0);
            l = (v % 2 == 1);
            send(vecs[v].cnt, vecs[v].thr, u, l);
            lat = 1;
            @(negedge aclk);
            while (!m_tvalid && lat < 20) begin
                cycle();
                lat++;
                @(negedge aclk);
            end
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(5));
            chk($sformatf("vec%0d_class", v), 64'(m_tclass), 64'(vecs[v].ecls));
            chk($sformatf("vec%0d_max", v), 64'(m_tmax), 64'(vecs[v].emax));
            chk($sformatf("vec%0d_user_last", v), 64'({m_tuser, m_tlast}), 64'({u, l}));
            cycle();
        end
        idle(8);

        // Random traffic with bubbles and 50% output backpressure.
        begin
            int out0;
            int guard;
            out0     = n_out;
            rnd_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 1000; i++) begin
                        logic [NC*CW-1:0] c;
                        if ($urandom_range(0, 3) == 0) idle(1);
                        for (int k = 0; k < NC; k++)
                            c[k*CW +: CW] = (i % 2 == 1) ? CW'($urandom_range(0, 7))
                                                         : CW'($urandom_range(0, 2));
                        send(c, CW'($urandom_range(0, 4)), ($urandom_range(0, 15) == 0),
                             1'($urandom_range(0, 1)));
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        m_tready = 1'($urandom_range(0, 1));
                        cycle();
                    end
                    m_tready = 1'b1;
                end
            join
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                cycle();
                guard++;
            end
            chk("random_drained", 64'(exp_q.size()), 64'(0));
            chk("random_out_count", 64'(n_out - out0), 64'(1000));
        end

        // Two 4x4 frames: 10 class-2 pixels and 6 background, then a new frame.
        do_reset();
        for (int p = 0; p < 16; p++)
            send((p < 10) ? mk(0, 2, 5, -1, 0) : mk(0, -1, 0, -1, 0), 3'd1,
                 (p == 0), (p % 4 == 3));
        idle(10);
        chk("hist_first_pulses", 64'(hv_cnt), 64'(1));
        chk_hist("hist_first_zero", hv_snap, '0);
        send(mk(0, 0, 3, -1, 0), 3'd0, 1'b1, 1'b0);
        idle(10);
        hexp = '0;
        hexp[2*HW +: HW]  = HW'(10);
        hexp[10*HW +: HW] = HW'(6);
        chk("hist_second_pulses", 64'(hv_cnt), 64'(2));
        chk_hist("hist_frame1", hv_snap, hexp);
        chk_hist("hist_held", hist_counts, hexp);

        // Saturation on the narrow-bin instance.
        do_reset();
        for (int p = 0; p < 12; p++) send(mk(0, 5, 4, -1, 0), 3'd0, (p == 0), 1'b0);
        send(mk(0, 1, 4, -1, 0), 3'd0, 1'b1, 1'b0);
        idle(10);
        chk("sat_pulses", 64'(hv2_cnt), 64'(2));
        chk("sat_bin5", 64'(hv2_snap), 64'(7) << (5*HW2));
        chk("wide_bin5", 64'(hv_snap[5*HW +: HW]), 64'(12));

        // aclken low freezes a pending hist_valid; it clears after one enabled edge.
        begin
            int hv0;
            int guard;
            hv0 = hv_cnt;
            send(mk(0, 4, 2, -1, 0), 3'd0, 1'b1, 1'b0);
            guard = 0;
            @(negedge aclk);
            while (!m_tvalid && guard < 20) begin
                cycle();
                guard++;
                @(negedge aclk);
            end
            cycle();
            aclken = 1'b0;
            repeat (3) cycle();
            chk("freeze_hist_valid", 64'(hist_valid), 64'(1));
            chk("freeze_tready", 64'(s_tready), 64'(0));
            aclken = 1'b1;
            cycle();
            chk("unfreeze_hist_valid", 64'(hist_valid), 64'(0));
            chk("freeze_pulse_count", 64'(hv_cnt - hv0), 64'(1));
        end

        // Reset mid-frame discards pixels in flight and the histogram.
        begin
            int out0;
            for (int p = 0; p < 3; p++) send(mk(1, 7, 6, -1, 0), 3'd0, 1'b0, 1'b0);
            aresetn = 1'b0;
            cycle();
            chk("midreset_tvalid", 64'(m_tvalid), 64'(0));
            chk_hist("midreset_hist", hist_counts, '0);
            chk("midreset_hist_sat", 64'(hist_counts2), 64'(0));
            aresetn = 1'b1;
            out0 = n_out;
            idle(10);
            chk("midreset_no_output", 64'(n_out - out0), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
